tdm_demux4_rx: RTL and testbench

- Receive side of the 4-channel time-division link whose transmit side is the 4:1 mux tree driven by a 2-bit select.
- Takes one serialized slot per valid beat and tracks the slot index with its own counter, locked to a frame-sync marker on slot 0.
- Distributes slots 0..3 into a registered 4-channel parallel word.
- Flags loss of sync and counts completed frames.

---
 rtl/tdm_demux4_rx.sv | 85 ++++++++
 tb/tb_tdm_demux4_rx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux4_rx.sv
// 4-channel TDM receiver: slot counter locked to a slot-0 frame marker,
// shadow capture of slots 0..2 and a registered parallel frame on slot 3.
module tdm_demux4_rx #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   din,
  input  logic               din_valid,
  input  logic               sync,
  output logic [4*WIDTH-1:0] out,
  output logic               frame_valid,
  output logic [1:0]         slot,
  output logic               locked,
  output logic               sync_err,
  output logic [CNT_W-1:0]   frame_cnt
);

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sh0;
  logic [WIDTH-1:0] sh1;
  logic [WIDTH-1:0] sh2;

  assign locked = (state == LOCK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      slot        <= 2'd0;
      sh0         <= '0;
      sh1         <= '0;
      sh2         <= '0;
      out         <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (din_valid) begin
        case (state)
          HUNT: begin
            if (sync) begin
              sh0   <= din;
              slot  <= 2'd1;
              state <= LOCK;
            end
          end
          LOCK: begin
            if (sync) begin
              // a marker mid-frame restarts the frame on this beat
              sync_err <= (slot != 2'd0);
              sh0      <= din;
              slot     <= 2'd1;
            end else if (slot == 2'd0) begin
              sync_err <= 1'b1;
              state    <= HUNT;
              slot     <= 2'd0;
            end else if (slot == 2'd3) begin
              out         <= {din, sh2, sh1, sh0};
              frame_valid <= 1'b1;
              frame_cnt   <= frame_cnt + 1'b1;
              slot        <= 2'd0;
            end else begin
              if (slot == 2'd1) sh1 <= din;
              else              sh2 <= din;
              slot <= slot + 2'd1;
            end
          end
          default: begin
            state <= HUNT;
            slot  <= 2'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux4_rx.sv
// Scoreboard bench for tdm_demux4_rx: expected frames and sync errors are
// queued as stimulus is driven and retired when the DUT pulses its outputs.
module tb_tdm_demux4_rx;

  localparam int WIDTH = 1;
  localparam int CNT_W = 2;

  typedef struct {
    logic [3:0] w;
    logic [1:0] c;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             sync;
  logic [3:0]       out;
  logic             frame_valid;
  logic [1:0]       slot;
  logic             locked;
  logic             sync_err;
  logic [1:0]       frame_cnt;

  exp_t       sbq[$];
  int         errq[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         last_fv = -1;
  bit         b2b = 1'b0;
  logic [1:0] exp_cnt = '0;

  tdm_demux4_rx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .din_valid(din_valid),
    .sync(sync),
    .out(out),
    .frame_valid(frame_valid),
    .slot(slot),
    .locked(locked),
    .sync_err(sync_err),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // monitor: retire scoreboard entries on output pulses
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_valid && sync_err)
        check("fv_and_err", 1, 0);
      if (frame_valid) begin
        if (sbq.size() == 0) begin
          check("unexpected_frame", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("frame_out", {28'd0, out}, {28'd0, e.w});
          check("frame_cnt", {30'd0, frame_cnt}, {30'd0, e.c});
        end
        if (b2b && last_fv >= 0)
          check("fv_period", cyc - last_fv, 4);
        last_fv = cyc;
      end
      if (sync_err) begin
        if (errq.size() == 0) check("unexpected_err", 1, 0);
        else void'(errq.pop_front());
      end
    end
  end

  task automatic idle();
    @(negedge clk);
    din_valid = 1'b0;
    sync      = 1'b0;
    din       = '0;
  endtask

  task automatic beat(input logic s, input logic d);
    @(negedge clk);
    din_valid = 1'b1;
    sync      = s;
    din       = d;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst       = 1'b1;
    din_valid = 1'b0;
    sync      = 1'b0;
    din       = '0;
    repeat (n - 1) @(negedge clk);
    @(negedge clk);
    rst     = 1'b0;
    exp_cnt = '0;
  endtask

  task automatic send_frame(input logic [3:0] w, input int gap,
                            input bit first_err);
    for (int i = 0; i < 4; i++) begin
      if (i == 0 && first_err) errq.push_back(1);
      if (i == 3) begin
        exp_t e;
        exp_cnt = exp_cnt + 2'd1;
        e.w = w;
        e.c = exp_cnt;
        sbq.push_back(e);
      end
      beat(i == 0, w[i]);
      if (i < 3) begin
        for (int g = 0; g < gap; g++) begin
          idle();
          check("gap_slot", {30'd0, slot}, i + 1);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; din_valid = 1'b0; sync = 1'b0; din = '0;
    do_reset(2);
    check("rst_out", {28'd0, out}, 0);
    check("rst_fv", {31'd0, frame_valid}, 0);
    check("rst_err", {31'd0, sync_err}, 0);
    check("rst_slot", {30'd0, slot}, 0);
    check("rst_locked", {31'd0, locked}, 0);
    check("rst_cnt", {30'd0, frame_cnt}, 0);

    // basic frame 1101
    send_frame(4'b1101, 0, 1'b0);
    idle();
    check("t1_fv", {31'd0, frame_valid}, 1);
    check("t1_out", {28'd0, out}, 4'b1101);
    check("t1_cnt", {30'd0, frame_cnt}, 1);
    check("t1_locked", {31'd0, locked}, 1);
    check("t1_slot", {30'd0, slot}, 0);
    idle();
    check("t1_fv_pulse", {31'd0, frame_valid}, 0);

    // hunt ignores unmarked beats
    do_reset(1);
    for (int i = 0; i < 3; i++) begin
      beat(1'b0, 1'b1);
      idle();
      check("hunt_slot", {30'd0, slot}, 0);
      check("hunt_locked", {31'd0, locked}, 0);
    end
    send_frame(4'b1010, 0, 1'b0);
    idle();
    check("t2_out", {28'd0, out}, 4'b1010);
    check("t2_cnt", {30'd0, frame_cnt}, 1);

    // early marker at slot 2 restarts as frame 0110
    beat(1'b1, 1'b1);
    beat(1'b0, 1'b1);
    send_frame(4'b0110, 0, 1'b1);
    idle();
    check("t3_out", {28'd0, out}, 4'b0110);
    check("t3_cnt", {30'd0, frame_cnt}, 2);
    check("t3_locked", {31'd0, locked}, 1);

    // missing marker at slot 0 drops lock
    errq.push_back(1);
    beat(1'b0, 1'b1);
    idle();
    check("t4_err", {31'd0, sync_err}, 1);
    check("t4_locked", {31'd0, locked}, 0);
    check("t4_slot", {30'd0, slot}, 0);
    check("t4_out", {28'd0, out}, 4'b0110);

    // gapped frame
    send_frame(4'b1101, 2, 1'b0);
    idle();
    check("t5_out", {28'd0, out}, 4'b1101);
    check("t5_cnt", {30'd0, frame_cnt}, 3);

    // back-to-back frames with a 2-bit counter wrap
    do_reset(1);
    last_fv = -1;
    b2b = 1'b1;
    for (int f = 0; f < 5; f++)
      send_frame(4'($urandom_range(15)), 0, 1'b0);
    idle();
    b2b = 1'b0;
    check("t6_cnt", {30'd0, frame_cnt}, 1);

    // reset mid-frame
    beat(1'b1, 1'b1);
    beat(1'b0, 1'b1);
    do_reset(1);
    check("t7_out", {28'd0, out}, 0);
    check("t7_slot", {30'd0, slot}, 0);
    check("t7_locked", {31'd0, locked}, 0);
    check("t7_cnt", {30'd0, frame_cnt}, 0);
    send_frame(4'b1001, 0, 1'b0);
    idle();
    check("t7_out2", {28'd0, out}, 4'b1001);
    check("t7_cnt2", {30'd0, frame_cnt}, 1);

    repeat (3) idle();
    check("sb_frames_left", sbq.size(), 0);
    check("sb_errs_left", errq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
